// File: rtl/sram_pkt_reader_pkg.sv
// Shared definitions for the SRAM packet reader: default geometry, FSM states
// and the read-credit helper.
package sram_pkt_reader_pkg;

  localparam int SRAM_AW     = 14;
  localparam int SRAM_DW     = 16;
  localparam int DESC_LEN_W  = 12;
  localparam int SRAM_RD_LAT = 1;
  localparam int OUT_FDEPTH  = 4;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } rdState_t;

  // One more read fits only if every committed word still has a FIFO slot.
  function automatic logic creditOk(input int used, input int depth);
    return (used + 32'sd1) <= depth;
  endfunction

endpackage

// File: rtl/sram_pkt_reader_rd_fifo.sv
// Synchronous show-ahead FIFO holding returned SRAM words with their sop/eop tags.
// The head entry is visible on oHead whenever oEmpty is low.
module sram_pkt_reader_rd_fifo #(
  parameter int W     = 18,
  parameter int DEPTH = 4
) (
  input  logic                       iClk,
  input  logic                       iRst_n,
  input  logic                       iPush,
  input  logic [W-1:0]               iPushData,
  input  logic                       iPop,
  output logic [W-1:0]               oHead,
  output logic [$clog2(DEPTH+1)-1:0] oCount,
  output logic                       oEmpty,
  output logic                       oFull
);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [W-1:0]  mem_r [DEPTH];
  logic [PW-1:0] wrPtr_r, rdPtr_r;
  logic [CW-1:0] count_r;
  logic          pushOk_s, popOk_s;

  function automatic logic [PW-1:0] ptrInc(input logic [PW-1:0] p);
    if (p == PW'(DEPTH - 1)) begin
      return '0;
    end else begin
      return p + PW'(1);
    end
  endfunction

  assign oEmpty   = (count_r == CW'(0));
  assign oFull    = (count_r == CW'(DEPTH));
  assign oCount   = count_r;
  assign oHead    = mem_r[rdPtr_r];
  assign popOk_s  = iPop & ~oEmpty;
  // A full FIFO still takes a push when the head leaves in the same cycle.
  assign pushOk_s = iPush & (~oFull | popOk_s);

  // Storage array; contents are don't-care until written.
  always_ff @(posedge iClk) begin
    if (pushOk_s) begin
      mem_r[wrPtr_r] <= iPushData;
    end
  end

  // Pointers and occupancy.
  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      wrPtr_r <= '0;
      rdPtr_r <= '0;
      count_r <= '0;
    end else begin
      if (pushOk_s) wrPtr_r <= ptrInc(wrPtr_r);
      if (popOk_s)  rdPtr_r <= ptrInc(rdPtr_r);
      case ({pushOk_s, popOk_s})
        2'b10:   count_r <= count_r + CW'(1);
        2'b01:   count_r <= count_r - CW'(1);
        default: count_r <= count_r;
      endcase
    end
  end

endmodule

// File: rtl/sram_pkt_reader.sv
// Read-side SRAM initiator: takes a (start, length) descriptor, issues
// credit-limited reads and streams the frame out with valid/ready and sop/eop.
module sram_pkt_reader
  import sram_pkt_reader_pkg::*;
#(
  parameter int AW     = SRAM_AW,
  parameter int DW     = SRAM_DW,
  parameter int LEN_W  = DESC_LEN_W,
  parameter int RD_LAT = SRAM_RD_LAT,
  parameter int FDEPTH = OUT_FDEPTH
) (
  input  logic             iClk,
  input  logic             iRst_n,
  input  logic             iDescValid,
  output logic             oDescReady,
  input  logic [AW-1:0]    iDescAddr,
  input  logic [LEN_W-1:0] iDescLen,
  output logic             oCEn,
  output logic             oWEn,
  output logic [DW-1:0]    oBWEn,
  output logic [AW-1:0]    oAddr,
  input  logic [DW-1:0]    iRData,
  output logic             oValid,
  input  logic             iReady,
  output logic [DW-1:0]    oData,
  output logic             oSop,
  output logic             oEop,
  output logic             oDone
);
  localparam int FW = DW + 2;
  localparam int CW = $clog2(FDEPTH + 1);

  rdState_t         state_r, nextState_s;
  logic [AW-1:0]    curAddr_r, srcAddr_s, addr_r;
  logic [LEN_W-1:0] remaining_r, srcRem_s;
  logic             firstFlag_r, srcFirst_s, accept_s, issue_s, credit_s;
  logic             ceN_r, descReady_r, done_r, eopSeen_r, eopDone_s, emptyAfter_s;
  logic [RD_LAT:0]  tagVld_r, tagSop_r, tagEop_r;
  int               inflight_s;
  logic             pop_s, fifoEmpty_s, fifoFull_s;
  logic [FW-1:0]    head_s;
  logic [CW-1:0]    fifoCount_s;

  assign oCEn       = ceN_r;
  assign oWEn       = 1'b1;
  assign oBWEn      = {DW{1'b1}};
  assign oAddr      = addr_r;
  assign oDescReady = descReady_r;
  assign oDone      = done_r;
  assign oValid     = ~fifoEmpty_s;
  assign pop_s      = ~fifoEmpty_s & iReady;

  sram_pkt_reader_rd_fifo #(.W(FW), .DEPTH(FDEPTH)) uFifo (
    .iClk      (iClk),
    .iRst_n    (iRst_n),
    .iPush     (tagVld_r[RD_LAT]),
    .iPushData ({iRData, tagSop_r[RD_LAT], tagEop_r[RD_LAT]}),
    .iPop      (pop_s),
    .oHead     (head_s),
    .oCount    (fifoCount_s),
    .oEmpty    (fifoEmpty_s),
    .oFull     (fifoFull_s)
  );

  // Output beat: FIFO head, forced to zero when nothing is valid.
  always_comb begin
    if (fifoEmpty_s) begin
      oData = '0;
      oSop  = 1'b0;
      oEop  = 1'b0;
    end else begin
      oData = head_s[FW-1:2];
      oSop  = head_s[1];
      oEop  = head_s[0];
    end
  end

  // Next state, read issue and credit; every tag stage counts as in flight
  // until its word has been pushed.
  always_comb begin
    nextState_s = state_r;
    accept_s    = 1'b0;
    issue_s     = 1'b0;
    srcAddr_s   = curAddr_r;
    srcRem_s    = remaining_r;
    srcFirst_s  = firstFlag_r;
    inflight_s  = 32'sd0;
    for (int i = 0; i <= RD_LAT; i++) begin
      inflight_s = inflight_s + int'(tagVld_r[i]);
    end
    credit_s     = creditOk(int'(fifoCount_s) + inflight_s, FDEPTH) & ~fifoFull_s;
    eopDone_s    = eopSeen_r | (pop_s & head_s[0]);
    emptyAfter_s = fifoEmpty_s | ((fifoCount_s == CW'(1)) & pop_s);
    case (state_r)
      S_IDLE: begin
        if (iDescValid && descReady_r) begin
          accept_s   = 1'b1;
          srcAddr_s  = iDescAddr;
          srcRem_s   = iDescLen;
          srcFirst_s = 1'b1;
          if (iDescLen != '0) begin
            nextState_s = S_RUN;
            issue_s     = credit_s;
          end else begin
            nextState_s = S_DONE;
          end
        end else begin
          nextState_s = S_IDLE;
        end
      end
      S_RUN: begin
        if (remaining_r == '0) begin
          nextState_s = S_DRAIN;
        end else begin
          issue_s = credit_s;
          if (credit_s && (remaining_r == LEN_W'(1))) begin
            nextState_s = S_DRAIN;
          end else begin
            nextState_s = S_RUN;
          end
        end
      end
      S_DRAIN: begin
        if ((inflight_s == 32'sd0) && eopDone_s && emptyAfter_s) begin
          nextState_s = S_DONE;
        end else begin
          nextState_s = S_DRAIN;
        end
      end
      S_DONE:  nextState_s = S_IDLE;
      default: nextState_s = S_IDLE;
    endcase
  end

  // State, counters, registered SRAM strobes and the read-tag pipeline.
  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      state_r     <= S_IDLE;
      curAddr_r   <= '0;
      remaining_r <= '0;
      firstFlag_r <= 1'b0;
      ceN_r       <= 1'b1;
      addr_r      <= '0;
      descReady_r <= 1'b0;
      done_r      <= 1'b0;
      eopSeen_r   <= 1'b0;
      tagVld_r    <= '0;
      tagSop_r    <= '0;
      tagEop_r    <= '0;
    end else begin
      state_r     <= nextState_s;
      descReady_r <= (nextState_s == S_IDLE);
      done_r      <= (nextState_s == S_DONE);
      ceN_r       <= ~issue_s;
      if (issue_s) begin
        addr_r      <= srcAddr_s;
        curAddr_r   <= srcAddr_s + AW'(1);
        remaining_r <= srcRem_s - LEN_W'(1);
        firstFlag_r <= 1'b0;
      end else if (accept_s) begin
        curAddr_r   <= srcAddr_s;
        remaining_r <= srcRem_s;
        firstFlag_r <= 1'b1;
      end else begin
        curAddr_r   <= curAddr_r;
        remaining_r <= remaining_r;
        firstFlag_r <= firstFlag_r;
      end
      if (accept_s) begin
        eopSeen_r <= 1'b0;
      end else if (pop_s && head_s[0]) begin
        eopSeen_r <= 1'b1;
      end else begin
        eopSeen_r <= eopSeen_r;
      end
      tagVld_r <= {tagVld_r[RD_LAT-1:0], issue_s};
      tagSop_r <= {tagSop_r[RD_LAT-1:0], srcFirst_s};
      tagEop_r <= {tagEop_r[RD_LAT-1:0], (srcRem_s == LEN_W'(1))};
    end
  end

endmodule

// File: tb/tb_sram_pkt_reader.sv
// Self-checking bench for sram_pkt_reader: directed descriptor table, reset and
// backpressure sequences, then random frames checked against an SRAM array model.
module tb_sram_pkt_reader;

  logic        iClk = 1'b0;
  logic        iRst_n = 1'b0;
  logic        iDescValid;
  logic        oDescReady;
  logic [13:0] iDescAddr;
  logic [11:0] iDescLen;
  logic        oCEn, oWEn;
  logic [15:0] oBWEn;
  logic [13:0] oAddr;
  logic [15:0] iRData = 16'h0000;
  logic        oValid;
  logic        iReady = 1'b1;
  logic [15:0] oData;
  logic        oSop, oEop, oDone;

  sram_pkt_reader dut (
    .iClk(iClk), .iRst_n(iRst_n), .iDescValid(iDescValid), .oDescReady(oDescReady),
    .iDescAddr(iDescAddr), .iDescLen(iDescLen), .oCEn(oCEn), .oWEn(oWEn), .oBWEn(oBWEn),
    .oAddr(oAddr), .iRData(iRData), .oValid(oValid), .iReady(iReady), .oData(oData),
    .oSop(oSop), .oEop(oEop), .oDone(oDone)
  );

  always #5 iClk = ~iClk;

  // SRAM model: one-cycle read latency.
  logic [15:0] mem [16384];
  always @(posedge iClk) begin
    if (!oCEn) iRData <= mem[oAddr];
  end

  typedef struct {logic [15:0] data; logic sop; logic eop; int cyc;} beat_t;
  beat_t       beatQ[$];
  int          ceCycQ[$];
  logic [13:0] ceAddrQ[$];
  int          doneQ[$];
  int          accQ[$];
  int          readyRiseQ[$];
  int          latQ[$];
  int cyc = 0, outNow = 0, maxOut = 0, stallErr = 0, stallCyc = 0, validCyc = 0;
  logic prevStall = 1'b0, prevReady = 1'b0;
  logic [15:0] prevData = 16'h0000;
  int nTests = 0, nFail = 0;
  int readyMode = 0, modeStart = 0;
  int snapBeat, snapCe, snapDone, snapAcc, snapValid;

  always @(posedge iClk) cyc <= cyc + 1;

  // Observer: records beats, reads, done pulses and accepts with cycle stamps.
  always @(negedge iClk) begin : mon
    int o;
    if (!iRst_n) begin
      outNow    <= 0;
      prevStall <= 1'b0;
      prevReady <= 1'b0;
    end else begin
      if (oValid && iReady) beatQ.push_back('{oData, oSop, oEop, cyc});
      if (!oCEn) begin
        ceCycQ.push_back(cyc);
        ceAddrQ.push_back(oAddr);
      end
      if (oDone) doneQ.push_back(cyc);
      if (iDescValid && oDescReady) accQ.push_back(cyc);
      if (oDescReady && !prevReady) readyRiseQ.push_back(cyc);
      if (oValid) validCyc <= validCyc + 1;
      o = outNow + (!oCEn ? 1 : 0);
      if (o > maxOut) maxOut <= o;
      outNow <= o - ((oValid && iReady) ? 1 : 0);
      if (prevStall) begin
        stallCyc <= stallCyc + 1;
        if (!oValid || oData !== prevData) stallErr <= stallErr + 1;
      end
      prevStall <= oValid && !iReady;
      prevData  <= oData;
      prevReady <= oDescReady;
    end
  end

  // Downstream ready pattern generator.
  always @(posedge iClk) begin : rdyDrv
    int idx;
    #1;
    idx = cyc - modeStart;
    case (readyMode)
      0: iReady = 1'b1;
      1: iReady = (idx < 8) ? (idx % 2 == 0) : (idx >= 14);
      2: iReady = ($urandom_range(0, 3) != 0);
      default: iReady = 1'b1;
    endcase
  end

  initial begin
    #800000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    nTests++;
    if (act !== exp) begin
      nFail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge iClk);
    #1;
  endtask

  task automatic sendDesc(input logic [13:0] a, input logic [11:0] l);
    bit acc = 0;
    iDescAddr  = a;
    iDescLen   = l;
    iDescValid = 1'b1;
    for (int n = 0; n < 40; n++) begin
      if (oDescReady) begin
        tick();
        acc = 1;
        break;
      end
      tick();
    end
    iDescValid = 1'b0;
    chk("descAccept", acc, 1);
  endtask

  task automatic takeSnap();
    snapBeat  = beatQ.size();
    snapCe    = ceCycQ.size();
    snapDone  = doneQ.size();
    snapAcc   = accQ.size();
    snapValid = validCyc;
  endtask

  task automatic runFrame(input logic [13:0] a, input logic [11:0] l, input int mode);
    bit found = 0;
    readyMode = mode;
    modeStart = cyc;
    takeSnap();
    sendDesc(a, l);
    for (int n = 0; n < 400; n++) begin
      if (oDone) begin
        found = 1;
        break;
      end
      tick();
    end
    chk("doneSeen", found, 1);
    tick();
    tick();
  endtask

  // Compare everything observed since the snapshot with the SRAM model.
  task automatic frameCheck(input logic [13:0] a, input logic [11:0] l);
    int nb, nc, errs, aerr;
    nb = beatQ.size() - snapBeat;
    nc = ceCycQ.size() - snapCe;
    errs = 0;
    aerr = 0;
    chk("beatCount", nb, l);
    for (int i = 0; i < nb; i++) begin
      beat_t b;
      logic [13:0] ea;
      b  = beatQ[snapBeat + i];
      ea = a + 14'(i);
      if (b.data !== mem[ea] || b.sop !== (i == 0) || b.eop !== (i == int'(l) - 1)) begin
        if (errs == 0)
          $display("FAIL beat %0d of frame @%h: got %h sop=%b eop=%b, expected %h", i, a, b.data, b.sop, b.eop, mem[ea]);
        errs++;
      end
    end
    chk("beatContent", errs, 0);
    chk("readCount", nc, l);
    for (int i = 0; i < nc; i++) begin
      if (ceAddrQ[snapCe + i] !== a + 14'(i)) aerr++;
    end
    chk("readAddrSeq", aerr, 0);
    chk("donePulses", doneQ.size() - snapDone, 1);
    if (nb > 0 && nb == int'(l) && doneQ.size() > snapDone)
      chk("doneAfterEop", doneQ[snapDone] - beatQ[snapBeat + nb - 1].cyc, 1);
  endtask

  typedef struct {
    logic [13:0] addr;
    logic [11:0] len;
    int          mode;
    logic [15:0] expFirst;
    logic [15:0] expLast;
  } vec_t;
  vec_t vecs[4];

  initial begin
    int acc, nb, eops, errs;
    bit got3;
    iDescValid = 1'b0;
    iDescAddr  = 14'h0;
    iDescLen   = 12'h0;
    for (int i = 0; i < 16384; i++) mem[i] = 16'($urandom);
    mem[14'h000F] = 16'h1234;
    for (int i = 0; i < 8; i++) mem[14'h1000 + i] = 16'hA000 + 16'(i);
    mem[14'h3FFE] = 16'hDEAD;
    mem[14'h3FFF] = 16'hBEEF;
    mem[14'h0000] = 16'hCAFE;
    vecs[0] = '{14'h000F, 12'd1, 0, 16'h1234, 16'h1234};
    vecs[1] = '{14'h1000, 12'd8, 0, 16'hA000, 16'hA007};
    vecs[2] = '{14'h3FFE, 12'd3, 0, 16'hDEAD, 16'hCAFE};
    vecs[3] = '{14'h0123, 12'd0, 0, 16'h0000, 16'h0000};

    tick();
    tick();
    chk("rstDescReady", oDescReady, 0);
    chk("rstCEn", oCEn, 1);
    chk("rstWEn", oWEn, 1);
    chk("rstBWEn", oBWEn, 16'hFFFF);
    chk("rstAddr", oAddr, 0);
    chk("rstValid", oValid, 0);
    chk("rstSopEop", {oSop, oEop}, 0);
    chk("rstDone", oDone, 0);
    chk("rstData", oData, 0);
    #2 iRst_n = 1'b1;
    tick();
    tick();
    chk("readyAfterReset", oDescReady, 1);

    foreach (vecs[k]) begin
      runFrame(vecs[k].addr, vecs[k].len, vecs[k].mode);
      frameCheck(vecs[k].addr, vecs[k].len);
      acc = (accQ.size() > snapAcc) ? accQ[snapAcc] : 0;
      nb  = beatQ.size() - snapBeat;
      if (vecs[k].mode == 0) chk("validCycles", validCyc - snapValid, vecs[k].len);
      if (nb > 0) begin
        chk("firstWord", beatQ[snapBeat].data, vecs[k].expFirst);
        chk("lastWord", beatQ[snapBeat + nb - 1].data, vecs[k].expLast);
      end
      if (vecs[k].len != 12'd0 && vecs[k].mode == 0 && nb > 0 && ceCycQ.size() > snapCe) begin
        chk("ceLatency", ceCycQ[snapCe] - acc, 1);
        chk("validLatencyRange", (beatQ[snapBeat].cyc - acc == 2) || (beatQ[snapBeat].cyc - acc == 3), 1);
        latQ.push_back(beatQ[snapBeat].cyc - acc);
        chk("ceBackToBack", ceCycQ[ceCycQ.size() - 1] - ceCycQ[snapCe], int'(vecs[k].len) - 1);
        chk("beatsBackToBack", beatQ[snapBeat + nb - 1].cyc - beatQ[snapBeat].cyc, int'(vecs[k].len) - 1);
      end
      if (vecs[k].len == 12'd0 && readyRiseQ.size() > 0)
        chk("readyReturnLen0", (readyRiseQ[readyRiseQ.size() - 1] - acc) <= 3, 1);
    end

    // Backpressure: 1010 then six low cycles.
    begin
      int s0, c0;
      s0 = stallErr;
      c0 = stallCyc;
      runFrame(14'h1000, 12'd8, 1);
      frameCheck(14'h1000, 12'd8);
      chk("stallDataStable", stallErr - s0, 0);
      chk("stallsOccurred", (stallCyc - c0) > 0, 1);
      if (ceCycQ.size() > snapCe)
        chk("ceStalled", (ceCycQ[ceCycQ.size() - 1] - ceCycQ[snapCe]) > 7, 1);
      chk("occupancyBound", maxOut <= 4, 1);
    end

    // Asynchronous reset in the middle of a frame.
    readyMode = 0;
    takeSnap();
    sendDesc(14'h1000, 12'd8);
    got3 = 0;
    for (int n = 0; n < 60; n++) begin
      if (beatQ.size() - snapBeat >= 3) begin
        got3 = 1;
        break;
      end
      tick();
    end
    chk("midFrameBeats", got3, 1);
    #2 iRst_n = 1'b0;
    #1;
    chk("arstDescReady", oDescReady, 0);
    chk("arstCEn", oCEn, 1);
    chk("arstAddr", oAddr, 0);
    chk("arstValid", oValid, 0);
    chk("arstSopEop", {oSop, oEop}, 0);
    chk("arstDone", oDone, 0);
    chk("arstData", oData, 0);
    eops = 0;
    errs = 0;
    for (int i = snapBeat; i < beatQ.size(); i++) begin
      if (beatQ[i].eop) eops++;
      if (beatQ[i].data !== 16'hA000 + 16'(i - snapBeat)) errs++;
    end
    chk("abortNoEop", eops, 0);
    chk("abortPrefixData", errs, 0);
    tick();
    tick();
    iRst_n = 1'b1;
    tick();
    runFrame(14'h000F, 12'd1, 0);
    frameCheck(14'h000F, 12'd1);
    if (beatQ.size() > snapBeat)
      chk("afterResetWord", {beatQ[snapBeat].data, beatQ[snapBeat].sop, beatQ[snapBeat].eop}, {16'h1234, 2'b11});

    // Random frames with random backpressure.
    for (int r = 0; r < 40; r++) begin
      logic [13:0] a;
      logic [11:0] l;
      a = ($urandom_range(0, 3) == 0) ? 14'(16383 - $urandom_range(0, 10)) : 14'($urandom_range(0, 16383));
      l = 12'($urandom_range(0, 20));
      runFrame(a, l, ($urandom_range(0, 4) == 0) ? 0 : 2);
      frameCheck(a, l);
    end

    for (int i = 1; i < latQ.size(); i++) chk("validLatencyFixed", latQ[i], latQ[0]);
    chk("occupancyBoundFinal", maxOut <= 4, 1);
    chk("stallDataStableFinal", stallErr, 0);

    $display("[TB] %0d tests run, %0d failed", nTests, nFail);
    $finish;
  end

endmodule
